// File: rtl/me_pixel_feeder.sv
// me_pixel_feeder: serves need_cur / need_ref by fetching MEM_W-bit beats over one
// shared read port and assembling CUR_W / REF_W words. Define ME_FEED_STATS_EN for word counters.
module me_pixel_feeder #(
   parameter int unsigned       PIX_W    = 8,
   parameter int unsigned       MEM_W    = 32,
   parameter int unsigned       CUR_W    = 32,
   parameter int unsigned       REF_W    = 64,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] CUR_BASE = '0,
   parameter int unsigned       CUR_SIZE = 8294400,
   parameter logic [ADDR_W-1:0] REF_BASE = ADDR_W'(8388608),
   parameter int unsigned       REF_SIZE = 23945760,
   parameter int unsigned       ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              need_cur,
   input  logic              need_ref,
   output logic [CUR_W-1:0]  cur_in,
   output logic              cur_valid,
   output logic [REF_W-1:0]  ref_in,
   output logic              ref_valid,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [MEM_W-1:0]  mem_rdata,
   input  logic              mem_rvalid,
   output logic              req_ovf,
   output logic [31:0]       cur_cnt,
   output logic [31:0]       ref_cnt
);

   localparam int unsigned CUR_BEATS  = CUR_W / MEM_W;
   localparam int unsigned REF_BEATS  = REF_W / MEM_W;
   localparam int unsigned MAX_BEATS  = (CUR_BEATS > REF_BEATS) ? CUR_BEATS : REF_BEATS;
   localparam int unsigned BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int unsigned STAGE_W    = (CUR_W > REF_W) ? CUR_W : REF_W;
   localparam int unsigned BEAT_BYTES = MEM_W / PIX_W;
   localparam int unsigned CUR_BYTES  = CUR_W / PIX_W;
   localparam int unsigned REF_BYTES  = REF_W / PIX_W;

   localparam logic [BEAT_W-1:0] CUR_LAST = BEAT_W'(CUR_BEATS - 1);
   localparam logic [BEAT_W-1:0] REF_LAST = BEAT_W'(REF_BEATS - 1);
   localparam logic [ADDR_W-1:0] CUR_WRAP = CUR_BASE + ADDR_W'(CUR_SIZE) - ADDR_W'(CUR_BYTES);
   localparam logic [ADDR_W-1:0] REF_WRAP = REF_BASE + ADDR_W'(REF_SIZE) - ADDR_W'(REF_BYTES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state, state_nxt;
   logic                pend_cur, pend_ref;
   logic                sel_ref, last_ref;
   logic                start, grant_ref;
   logic [BEAT_W-1:0]   beat;
   logic [STAGE_W-1:0]  stage, stage_mrg;
   logic [ADDR_W-1:0]   cur_addr, ref_addr, stream_addr, beat_off;
   logic                last_beat, beat_ack, word_done;

   // Memory handshake: mem_req/mem_addr stay stable until the cycle mem_gnt is high
   // (that cycle is the transfer); one beat is outstanding until its mem_rvalid cycle.
   assign stream_addr = sel_ref ? ref_addr : cur_addr;
   assign beat_off    = ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);
   assign mem_req     = (state == REQ);
   assign mem_addr    = mem_req ? stream_addr + beat_off : '0;
   assign last_beat   = (beat == (sel_ref ? REF_LAST : CUR_LAST));
   assign beat_ack    = (state == WAIT) && mem_rvalid;
   assign word_done   = beat_ack && last_beat;

   always_comb begin
      stage_mrg = stage;
      stage_mrg[int'(beat) * MEM_W +: MEM_W] = mem_rdata;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      grant_ref = 1'b0;
      case (state)
         IDLE: begin
            if (pend_cur || pend_ref) begin
               start     = 1'b1;
               state_nxt = REQ;
               if (ARB_MODE == 1 && pend_cur && pend_ref)
                  grant_ref = ~last_ref;
               else
                  grant_ref = ~pend_cur;
            end
         end
         REQ:     if (mem_gnt) state_nxt = WAIT;
         WAIT:    if (mem_rvalid) state_nxt = last_beat ? IDLE : REQ;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pend_cur  <= 1'b0;
         pend_ref  <= 1'b0;
         sel_ref   <= 1'b0;
         last_ref  <= 1'b1;
         beat      <= '0;
         stage     <= '0;
         cur_addr  <= CUR_BASE;
         ref_addr  <= REF_BASE;
         cur_in    <= '0;
         ref_in    <= '0;
         cur_valid <= 1'b0;
         ref_valid <= 1'b0;
         req_ovf   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_valid <= 1'b0;
         ref_valid <= 1'b0;

         // A pulse that finds its flag already set is dropped, even on the completing edge.
         pend_cur <= (pend_cur & ~(word_done & ~sel_ref)) | (need_cur & ~pend_cur);
         pend_ref <= (pend_ref & ~(word_done & sel_ref)) | (need_ref & ~pend_ref);
         if ((need_cur && pend_cur) || (need_ref && pend_ref))
            req_ovf <= 1'b1;

         if (start) begin
            sel_ref  <= grant_ref;
            last_ref <= grant_ref;
            beat     <= '0;
         end

         if (beat_ack) begin
            stage <= stage_mrg;
            if (!last_beat)
               beat <= beat + BEAT_W'(1);
         end

         if (word_done) begin
            if (sel_ref) begin
               ref_in    <= stage_mrg[REF_W-1:0];
               ref_valid <= 1'b1;
               ref_addr  <= (ref_addr == REF_WRAP) ? REF_BASE : ref_addr + ADDR_W'(REF_BYTES);
            end else begin
               cur_in    <= stage_mrg[CUR_W-1:0];
               cur_valid <= 1'b1;
               cur_addr  <= (cur_addr == CUR_WRAP) ? CUR_BASE : cur_addr + ADDR_W'(CUR_BYTES);
            end
         end
      end
   end

`ifdef ME_FEED_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_cnt <= '0;
         ref_cnt <= '0;
      end else begin
         if (word_done && !sel_ref) cur_cnt <= cur_cnt + 32'd1;
         if (word_done && sel_ref)  ref_cnt <= ref_cnt + 32'd1;
      end
   end
`else
   assign cur_cnt = '0;
   assign ref_cnt = '0;
`endif

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Bench for me_pixel_feeder: two instances (fixed priority and round-robin, 8-byte cur frame)
// fed by a behavioural memory whose byte at address a is a[7:0].
module tb_me_pixel_feeder;

   localparam int unsigned CUR_SZ   = 8;
   localparam int unsigned REF_BASE = 8388608;
   localparam int unsigned REF_SZ   = 23945760;
`ifdef ME_FEED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        need_cur = 1'b0;
   logic        need_ref = 1'b0;
   logic [31:0] cur_in[2];
   logic        cur_valid[2];
   logic [63:0] ref_in[2];
   logic        ref_valid[2];
   logic        mem_req[2];
   logic [31:0] mem_addr[2];
   logic        mem_gnt[2]    = '{1'b0, 1'b0};
   logic [31:0] mem_rdata[2]  = '{32'h0, 32'h0};
   logic        mem_rvalid[2] = '{1'b0, 1'b0};
   logic        req_ovf[2];
   logic [31:0] cur_cnt[2];
   logic [31:0] ref_cnt[2];

   me_pixel_feeder #(.CUR_SIZE(CUR_SZ), .ARB_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref),
      .cur_in(cur_in[0]), .cur_valid(cur_valid[0]), .ref_in(ref_in[0]), .ref_valid(ref_valid[0]),
      .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_gnt(mem_gnt[0]),
      .mem_rdata(mem_rdata[0]), .mem_rvalid(mem_rvalid[0]),
      .req_ovf(req_ovf[0]), .cur_cnt(cur_cnt[0]), .ref_cnt(ref_cnt[0]));

   me_pixel_feeder #(.CUR_SIZE(CUR_SZ), .ARB_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .need_cur(need_cur), .need_ref(need_ref),
      .cur_in(cur_in[1]), .cur_valid(cur_valid[1]), .ref_in(ref_in[1]), .ref_valid(ref_valid[1]),
      .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_gnt(mem_gnt[1]),
      .mem_rdata(mem_rdata[1]), .mem_rvalid(mem_rvalid[1]),
      .req_ovf(req_ovf[1]), .cur_cnt(cur_cnt[1]), .ref_cnt(ref_cnt[1]));

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [31:0] a, input int n);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(a + 32'(k));
      return w;
   endfunction

   // memory model: grant after glo..ghi idle cycles, data after rlo..rhi more; survives DUT reset
   int          glo = 0, ghi = 0, rlo = 0, rhi = 0;
   int          gdly[2]    = '{0, 0};
   int          rdly[2]    = '{0, 0};
   logic        rd_pend[2] = '{1'b0, 1'b0};
   logic [31:0] rd_addr[2] = '{32'h0, 32'h0};

   always @(posedge clk) begin
      logic [63:0] t;
      for (int i = 0; i < 2; i++) begin
         mem_gnt[i]    <= 1'b0;
         mem_rvalid[i] <= 1'b0;
         if (rd_pend[i]) begin
            if (rdly[i] == 0) begin
               t = word_of(rd_addr[i], 4);
               mem_rvalid[i] <= 1'b1;
               mem_rdata[i]  <= t[31:0];
               rd_pend[i]    <= 1'b0;
            end else rdly[i] <= rdly[i] - 1;
         end else if (mem_req[i] && !mem_gnt[i]) begin
            if (gdly[i] == 0) begin
               mem_gnt[i] <= 1'b1;
               rd_addr[i] <= mem_addr[i];
               rd_pend[i] <= 1'b1;
               rdly[i]    <= int'($urandom_range(rhi, rlo));
               gdly[i]    <= int'($urandom_range(ghi, glo));
            end else gdly[i] <= gdly[i] - 1;
         end
      end
   end

   // scoreboard: one expected queue per dut and stream
   logic [63:0] exp_q_c0[$], exp_q_c1[$], exp_q_r0[$], exp_q_r1[$];
   int unsigned cur_off[2], ref_off[2];
   int          acc_cur[2], acc_ref[2];
   logic        exp_ovf[2];
   logic [63:0] last_cur[2], last_ref[2];
   int          cur_seen[2], ev_cnt[2], cur_at[2], ref_at[2];
   logic [31:0] g_log[2][8];
   int          g_n[2];

   function automatic int q_size(input int i, input bit r);
      if (!r) return (i == 0) ? exp_q_c0.size() : exp_q_c1.size();
      return (i == 0) ? exp_q_r0.size() : exp_q_r1.size();
   endfunction

   function automatic void q_push(input int i, input bit r, input logic [63:0] w);
      if (!r && i == 0) exp_q_c0.push_back(w);
      else if (!r)      exp_q_c1.push_back(w);
      else if (i == 0)  exp_q_r0.push_back(w);
      else              exp_q_r1.push_back(w);
   endfunction

   function automatic logic [63:0] q_pop(input int i, input bit r);
      if (!r && i == 0) return exp_q_c0.pop_front();
      if (!r)           return exp_q_c1.pop_front();
      if (i == 0)       return exp_q_r0.pop_front();
      return exp_q_r1.pop_front();
   endfunction

   function automatic void model_need(input int i, input bit r);
      if (q_size(i, r) != 0) exp_ovf[i] = 1'b1;
      else if (!r) begin
         q_push(i, 0, word_of(cur_off[i], 4));
         cur_off[i] = (cur_off[i] + 4) % CUR_SZ;
         acc_cur[i]++;
      end else begin
         q_push(i, 1, word_of(REF_BASE + ref_off[i], 8));
         ref_off[i] = (ref_off[i] + 8) % REF_SZ;
         acc_ref[i]++;
      end
   endfunction

   function automatic void model_reset();
      exp_q_c0.delete(); exp_q_c1.delete(); exp_q_r0.delete(); exp_q_r1.delete();
      for (int i = 0; i < 2; i++) begin
         cur_off[i] = 0; ref_off[i] = 0; acc_cur[i] = 0; acc_ref[i] = 0;
         exp_ovf[i] = 1'b0; last_cur[i] = '0; last_ref[i] = '0;
      end
   endfunction

   task automatic mon_dut(input int i);
      if (mem_req[i] && mem_gnt[i]) begin
         if (g_n[i] < 8) g_log[i][g_n[i]] = mem_addr[i];
         g_n[i]++;
      end
      if (cur_valid[i]) begin
         cur_seen[i]++; ev_cnt[i]++; cur_at[i] = ev_cnt[i];
         check($sformatf("d%0d_cur_expected", i), q_size(i, 0) != 0, 1'b1);
         if (q_size(i, 0) != 0) last_cur[i] = q_pop(i, 0);
         check($sformatf("d%0d_cur_data", i), {32'h0, cur_in[i]}, last_cur[i]);
      end else
         check($sformatf("d%0d_cur_hold", i), {32'h0, cur_in[i]}, last_cur[i]);
      if (ref_valid[i]) begin
         ev_cnt[i]++; ref_at[i] = ev_cnt[i];
         check($sformatf("d%0d_ref_expected", i), q_size(i, 1) != 0, 1'b1);
         if (q_size(i, 1) != 0) last_ref[i] = q_pop(i, 1);
         check($sformatf("d%0d_ref_data", i), ref_in[i], last_ref[i]);
      end else
         check($sformatf("d%0d_ref_hold", i), ref_in[i], last_ref[i]);
   endtask

   always @(negedge clk) begin
      if (rst) for (int i = 0; i < 2; i++) mon_dut(i);
   end

   // driver tasks: inputs change #1 after the sampling negedge
   task automatic pulse(input bit c, input bit r);
      @(negedge clk); #1;
      need_cur = c; need_ref = r;
      for (int i = 0; i < 2; i++) begin
         if (c) model_need(i, 0);
         if (r) model_need(i, 1);
      end
      @(negedge clk); #1;
      need_cur = 1'b0; need_ref = 1'b0;
   endtask

   task automatic fetch_lat(input bit c, input bit r, output int lat);
      @(negedge clk); #1;
      need_cur = c; need_ref = r;
      for (int i = 0; i < 2; i++) begin
         if (c) model_need(i, 0);
         if (r) model_need(i, 1);
      end
      lat = -1;
      for (int n = 1; n <= 30 && lat < 0; n++) begin
         @(negedge clk);
         if ((c && cur_valid[0]) || (r && ref_valid[0])) lat = n - 1;
         if (n == 1) begin #1; need_cur = 1'b0; need_ref = 1'b0; end
      end
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n;
      n = 0;
      while ((exp_q_c0.size() + exp_q_c1.size() + exp_q_r0.size() + exp_q_r1.size()) != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(tag, n < max_cyc, 1'b1);
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_d%0d_cur_in", tag, i), {32'h0, cur_in[i]}, 64'h0);
         check($sformatf("%s_d%0d_ref_in", tag, i), ref_in[i], 64'h0);
         check($sformatf("%s_d%0d_valids", tag, i), {cur_valid[i], ref_valid[i]}, 2'b00);
         check($sformatf("%s_d%0d_mem_req", tag, i), mem_req[i], 1'b0);
         check($sformatf("%s_d%0d_mem_addr", tag, i), mem_addr[i], 32'h0);
         check($sformatf("%s_d%0d_req_ovf", tag, i), req_ovf[i], 1'b0);
         check($sformatf("%s_d%0d_cnts", tag, i), {cur_cnt[i], ref_cnt[i]}, 64'h0);
      end
   endtask

   task automatic check_stats(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_d%0d_cur_cnt", tag, i), cur_cnt[i], STATS ? 32'(acc_cur[i]) : 32'h0);
         check($sformatf("%s_d%0d_ref_cnt", tag, i), ref_cnt[i], STATS ? 32'(acc_ref[i]) : 32'h0);
      end
   endtask

   initial begin
      int lat;
      int seen0, seen1;
      bit c, r;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         cur_seen[i] = 0; ev_cnt[i] = 0; cur_at[i] = 0; ref_at[i] = 0; g_n[i] = 0;
      end

      // reset state
      repeat (3) @(negedge clk);
      check_zero("reset");
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);

      // cur alone: 4-cycle latency, pixels 0..3 from address 0
      g_n[0] = 0;
      fetch_lat(1'b1, 1'b0, lat);
      check("cur_latency", 64'(lat), 64'd4);
      check("cur_word", {32'h0, cur_in[0]}, 64'h03020100);
      check("cur_addr0", g_log[0][0], 32'h0);
      wait_idle(50, "cur_idle");
      check_stats("cur_stats");

      // ref alone: two beats, 7-cycle latency
      g_n[0] = 0;
      fetch_lat(1'b0, 1'b1, lat);
      check("ref_latency", 64'(lat), 64'd7);
      check("ref_word", ref_in[0], 64'h0706050403020100);
      check("ref_beats", g_n[0], 2);
      check("ref_addr_b0", g_log[0][0], 32'd8388608);
      check("ref_addr_b1", g_log[0][1], 32'd8388612);
      wait_idle(50, "ref_idle");

      // second cur word (address 4), leaves round-robin history at cur
      pulse(1'b1, 1'b0);
      wait_idle(50, "cur2_idle");
      check("cur2_word", {32'h0, cur_in[0]}, 64'h07060504);

      // simultaneous requests: fixed priority serves cur first, round-robin serves ref first;
      // the cur word wraps back to address 0
      g_n[0] = 0;
      pulse(1'b1, 1'b1);
      wait_idle(80, "both_idle");
      check("arb0_cur_first", cur_at[0] < ref_at[0], 1'b1);
      check("arb1_ref_first", ref_at[1] < cur_at[1], 1'b1);
      check("wrap_addr", g_log[0][0], 32'h0);
      check("wrap_word", {32'h0, cur_in[0]}, 64'h03020100);
      check_stats("both_stats");

      // second need_cur while pending is dropped and flags overflow
      check("ovf_before", {req_ovf[0], req_ovf[1]}, 2'b00);
      seen0 = cur_seen[0]; seen1 = cur_seen[1];
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      wait_idle(50, "ovf_idle");
      repeat (6) @(negedge clk);
      check("ovf_d0", req_ovf[0], exp_ovf[0]);
      check("ovf_d1", req_ovf[1], exp_ovf[1]);
      check("ovf_d0_one_word", cur_seen[0] - seen0, 1);
      check("ovf_d1_one_word", cur_seen[1] - seen1, 1);

      // reset while waiting for data; the stale response arrives after release
      rlo = 6; rhi = 6;
      pulse(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_zero("rst_wait");
      #1 rst = 1'b1;
      rlo = 0; rhi = 0;
      repeat (12) @(negedge clk);
      check_zero("stale");
      g_n[0] = 0; g_n[1] = 0;
      pulse(1'b1, 1'b0);
      wait_idle(50, "post_rst_idle");
      check("post_rst_addr_d0", g_log[0][0], 32'h0);
      check("post_rst_addr_d1", g_log[1][0], 32'h0);
      check("post_rst_word", {32'h0, cur_in[1]}, 64'h03020100);
      check_stats("post_rst_stats");

      // randomized requests against variable-latency memory
      glo = 0; ghi = 3; rlo = 0; rhi = 4;
      for (int n = 0; n < 400; n++) begin
         c = ($urandom_range(3, 0) == 0);
         r = ($urandom_range(3, 0) == 0);
         if (c || r) pulse(c, r);
         else @(negedge clk);
      end
      wait_idle(2000, "rand_idle");
      repeat (4) @(negedge clk);
      check("rand_ovf_d0", req_ovf[0], exp_ovf[0]);
      check("rand_ovf_d1", req_ovf[1], exp_ovf[1]);
      check_stats("rand_stats");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
